// File: rtl/mem_access_unit.sv
// Load/store engine: takes one request per handshake, runs one aligned bus transaction and
// returns the extended load data with an error code (misaligned, bus timeout, illegal request).
module mem_access_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_load,
    input  logic                    req_store,
    input  logic                    req_unsigned,
    input  logic [1:0]              req_length,
    input  logic [ADDR_WIDTH-1:0]   req_address,
    input  logic [DATA_WIDTH-1:0]   req_storeData,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_data,
    output logic [1:0]              resp_errCode,
    output logic                    bus_valid,
    input  logic                    bus_ready,
    output logic                    bus_write,
    output logic [ADDR_WIDTH-1:0]   bus_address,
    output logic [DATA_WIDTH-1:0]   bus_writeData,
    output logic [DATA_WIDTH/8-1:0] bus_byteEnable,
    input  logic [DATA_WIDTH-1:0]   bus_readData
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int OB = $clog2(NB);
    localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_MISALGN = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESPOND} state_t;

    state_t                  state_q, state_d;
    logic                    req_ready_q, req_ready_d;
    logic                    bus_valid_q, bus_valid_d;
    logic                    bus_write_q, bus_write_d;
    logic [ADDR_WIDTH-1:0]   bus_address_q, bus_address_d;
    logic [DATA_WIDTH-1:0]   bus_writeData_q, bus_writeData_d;
    logic [NB-1:0]           bus_byteEnable_q, bus_byteEnable_d;
    logic [OB-1:0]           off_q, off_d;
    logic [1:0]              len_q, len_d;
    logic                    unsigned_q, unsigned_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;
    logic [1:0]              resp_err_q, resp_err_d;

    logic                    accept;
    logic                    req_illegal;
    logic                    req_misaligned;
    logic [OB-1:0]           req_off;
    logic [OB-1:0]           len_mask;
    logic [NB-1:0]           req_be;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [DATA_WIDTH-1:0]   rd_shift;
    logic [DATA_WIDTH-1:0]   ld_data;
    logic                    ld_sign;
    logic [3:0]              nbytes_q;

    assign accept  = req_valid && req_ready_q;
    assign req_off = req_address[OB-1:0];

    // Request decode; a length wider than the bus is illegal, which also bounds the lane math.
    always_comb begin
        int o;
        int n;
        o = int'(req_off);
        n = 1 << req_length;
        req_illegal = (req_load == req_store) || (int'(req_length) > OB);
        for (int i = 0; i < OB; i++) len_mask[i] = (i < int'(req_length));
        req_misaligned = |(req_off & len_mask);
        for (int i = 0; i < NB; i++) req_be[i] = (i >= o) && (i < o + n);
        req_wdata = req_storeData << {req_off, 3'b000};
    end

    // Load extraction: move the addressed lane down, keep the access width, extend the rest.
    assign nbytes_q = 4'd1 << len_q;
    always_comb begin
        rd_shift = bus_readData >> {off_q, 3'b000};
        ld_sign  = 1'b0;
        ld_data  = '0;
        for (int i = 0; i < NB; i++)
            if (i == int'(nbytes_q) - 1) ld_sign = rd_shift[8*i+7];
        for (int i = 0; i < NB; i++) begin
            if (i < int'(nbytes_q)) ld_data[8*i +: 8] = rd_shift[8*i +: 8];
            else                    ld_data[8*i +: 8] = {8{ld_sign & ~unsigned_q}};
        end
    end

    always_comb begin
        state_d          = state_q;
        bus_valid_d      = bus_valid_q;
        bus_write_d      = bus_write_q;
        bus_address_d    = bus_address_q;
        bus_writeData_d  = bus_writeData_q;
        bus_byteEnable_d = bus_byteEnable_q;
        off_d            = off_q;
        len_d            = len_q;
        unsigned_d       = unsigned_q;
        tmo_d            = tmo_q;
        resp_valid_d     = resp_valid_q;
        resp_data_d      = resp_data_q;
        resp_err_d       = resp_err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    tmo_d      = '0;
                    off_d      = req_off;
                    len_d      = req_length;
                    unsigned_d = req_unsigned;
                    if (req_illegal || req_misaligned) begin
                        resp_valid_d = 1'b1;
                        resp_data_d  = '0;
                        resp_err_d   = req_illegal ? ERR_ILLEGAL : ERR_MISALGN;
                        state_d      = S_RESPOND;
                    end else begin
                        bus_valid_d      = 1'b1;
                        bus_write_d      = req_store;
                        bus_address_d    = {req_address[ADDR_WIDTH-1:OB], {OB{1'b0}}};
                        bus_writeData_d  = req_wdata;
                        bus_byteEnable_d = req_be;
                        state_d          = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                // bus_ready takes priority over a timeout landing in the same cycle.
                if (bus_ready || ((TIMEOUT_CYCLES != 0) && (tmo_q == TW'(TIMEOUT_CYCLES - 1)))) begin
                    resp_valid_d     = 1'b1;
                    resp_err_d       = bus_ready ? ERR_OK : ERR_TIMEOUT;
                    resp_data_d      = (bus_ready && !bus_write_q) ? ld_data : '0;
                    bus_valid_d      = 1'b0;
                    bus_write_d      = 1'b0;
                    bus_address_d    = '0;
                    bus_writeData_d  = '0;
                    bus_byteEnable_d = '0;
                    state_d          = S_RESPOND;
                end else if (tmo_q != '1) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_RESPOND: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_data_d  = '0;
                    resp_err_d   = ERR_OK;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        req_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= S_IDLE;
            req_ready_q      <= 1'b0;
            bus_valid_q      <= 1'b0;
            bus_write_q      <= 1'b0;
            bus_address_q    <= '0;
            bus_writeData_q  <= '0;
            bus_byteEnable_q <= '0;
            off_q            <= '0;
            len_q            <= '0;
            unsigned_q       <= 1'b0;
            tmo_q            <= '0;
            resp_valid_q     <= 1'b0;
            resp_data_q      <= '0;
            resp_err_q       <= ERR_OK;
        end else begin
            state_q          <= state_d;
            req_ready_q      <= req_ready_d;
            bus_valid_q      <= bus_valid_d;
            bus_write_q      <= bus_write_d;
            bus_address_q    <= bus_address_d;
            bus_writeData_q  <= bus_writeData_d;
            bus_byteEnable_q <= bus_byteEnable_d;
            off_q            <= off_d;
            len_q            <= len_d;
            unsigned_q       <= unsigned_d;
            tmo_q            <= tmo_d;
            resp_valid_q     <= resp_valid_d;
            resp_data_q      <= resp_data_d;
            resp_err_q       <= resp_err_d;
        end
    end

    assign req_ready      = req_ready_q;
    assign bus_valid      = bus_valid_q;
    assign bus_write      = bus_write_q;
    assign bus_address    = bus_address_q;
    assign bus_writeData  = bus_writeData_q;
    assign bus_byteEnable = bus_byteEnable_q;
    assign resp_valid     = resp_valid_q;
    assign resp_data      = resp_data_q;
    assign resp_errCode   = resp_err_q;

endmodule
